// File: rtl/serial_arbiter_pkg.sv
// rtl/serial_arbiter_pkg.sv - shared serial package: arbiter state encodings and limits
package serial_arbiter_pkg;

  localparam int BURST_MAX_DEFAULT = 8;
  localparam int IDLE_MAX_DEFAULT  = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arbState_t;

endpackage

// File: rtl/serial_arbiter.sv
// rtl/serial_arbiter.sv - two-port arbiter in front of the serial controller
// Owner writes are forwarded as registered pushes; reads are passed straight through.
module serial_arbiter
  import serial_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT,
  parameter int IDLE_MAX  = IDLE_MAX_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Lock0,
  input  logic        Lock1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [15:0] WrData0,
  input  logic [15:0] WrData1,
  input  logic        Rd0,
  input  logic        Rd1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic [15:0] RdData,
  output logic        RdValid0,
  output logic        RdValid1,
  output logic        Drop,
  output logic        SerSend,
  output logic [15:0] SerDataIn,
  output logic        SerRead,
  input  logic [15:0] SerDataOut,
  input  logic        SerValid
);

  arbState_t  state, nextState;
  logic       lastOwner;
  logic [7:0] wordCnt, idleCnt;
  logic       own0, own1, acc0, acc1, ownerActive, grantEntry, burstHit, idleHit;

  assign own0        = (state == ST_OWN0);
  assign own1        = (state == ST_OWN1);
  assign acc0        = Wr0 & own0;
  assign acc1        = Wr1 & own1;
  assign ownerActive = acc0 | acc1 | (Rd0 & own0) | (Rd1 & own1);
  assign grantEntry  = (state == ST_IDLE) & (Req0 | Req1);
  assign burstHit    = (wordCnt == 8'(BURST_MAX));
  assign idleHit     = (idleCnt == 8'(IDLE_MAX));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (Req0 && Req1) nextState = lastOwner ? ST_OWN0 : ST_OWN1;
        else if (Req0)    nextState = ST_OWN0;
        else if (Req1)    nextState = ST_OWN1;
      end
      ST_OWN0:
        if (!Req0 || (Req1 && ((burstHit && !Lock0) || idleHit))) nextState = ST_TURN;
      ST_OWN1:
        if (!Req1 || (Req0 && ((burstHit && !Lock1) || idleHit))) nextState = ST_TURN;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      lastOwner <= 1'b1;
      wordCnt   <= '0;
      idleCnt   <= '0;
      Gnt0      <= 1'b0;
      Gnt1      <= 1'b0;
      SerSend   <= 1'b0;
      SerDataIn <= '0;
      Drop      <= 1'b0;
    end else begin
      Gnt0 <= (nextState == ST_OWN0);
      Gnt1 <= (nextState == ST_OWN1);
      if (own0 && nextState == ST_TURN)      lastOwner <= 1'b0;
      else if (own1 && nextState == ST_TURN) lastOwner <= 1'b1;

      // Both counters saturate so a long-held grant never wraps into a false release
      if (grantEntry)                            wordCnt <= '0;
      else if ((acc0 | acc1) && wordCnt != '1)   wordCnt <= wordCnt + 8'd1;
      if (grantEntry || ownerActive)             idleCnt <= '0;
      else if (idleCnt != '1)                    idleCnt <= idleCnt + 8'd1;

      SerSend <= acc0 | acc1;
      if (acc0)      SerDataIn <= WrData0;
      else if (acc1) SerDataIn <= WrData1;
      Drop <= (Wr0 & ~own0) | (Wr1 & ~own1);
    end
  end

  assign RdData   = SerDataOut;
  assign RdValid0 = SerValid & Gnt0;
  assign RdValid1 = SerValid & Gnt1;
  assign SerRead  = SerValid & ((Rd0 & Gnt0) | (Rd1 & Gnt1));

endmodule

// File: tb/tb_serial_arbiter.sv
// tb/tb_serial_arbiter.sv - self-checking bench for serial_arbiter
module tb_serial_arbiter;

  localparam int BM = 8;
  localparam int IM = 255;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Req0, Req1, Lock0, Lock1, Wr0, Wr1, Rd0, Rd1, SerValid;
  logic [15:0] WrData0, WrData1, SerDataOut;
  logic        Gnt0, Gnt1, RdValid0, RdValid1, Drop, SerSend, SerRead;
  logic [15:0] RdData, SerDataIn;

  int nCmp = 0;
  int nBad = 0;

  serial_arbiter #(.BURST_MAX(BM), .IDLE_MAX(IM)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1), .Lock0(Lock0), .Lock1(Lock1),
    .Wr0(Wr0), .Wr1(Wr1), .WrData0(WrData0), .WrData1(WrData1),
    .Rd0(Rd0), .Rd1(Rd1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RdData(RdData),
    .RdValid0(RdValid0), .RdValid1(RdValid1), .Drop(Drop),
    .SerSend(SerSend), .SerDataIn(SerDataIn), .SerRead(SerRead),
    .SerDataOut(SerDataOut), .SerValid(SerValid)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how long since release, and what was sent
  int          mOwner = -1;
  int          mCool  = 0;
  int          mLast  = 1;
  int          mWords = 0;
  int          mIdle  = 0;
  bit          mSend  = 0;
  bit          mDrop  = 0;
  logic [15:0] mData  = '0;

  always @(posedge Clock or negedge Reset_n) begin : model
    bit acc0, acc1, myReq, otherReq, myLock, act, rel;
    if (!Reset_n) begin
      mOwner = -1; mCool = 0; mLast = 1; mWords = 0; mIdle = 0;
      mSend = 0; mDrop = 0; mData = '0;
    end else begin
      acc0 = Wr0 && (mOwner == 0);
      acc1 = Wr1 && (mOwner == 1);
      mDrop = (Wr0 && mOwner != 0) || (Wr1 && mOwner != 1);
      mSend = acc0 || acc1;
      if (acc0)      mData = WrData0;
      else if (acc1) mData = WrData1;
      if (mOwner >= 0) begin
        myReq    = (mOwner == 0) ? Req0 : Req1;
        otherReq = (mOwner == 0) ? Req1 : Req0;
        myLock   = (mOwner == 0) ? Lock0 : Lock1;
        act      = acc0 || acc1 || (mOwner == 0 ? Rd0 : Rd1);
        rel = !myReq || (otherReq && ((mWords == BM && !myLock) || mIdle == IM));
        if (acc0 || acc1) mWords = (mWords >= 255) ? 255 : mWords + 1;
        mIdle = act ? 0 : ((mIdle >= 255) ? 255 : mIdle + 1);
        if (rel) begin
          mLast = mOwner; mOwner = -1; mCool = 1;
        end
      end else if (mCool > 0) begin
        mCool = 0;
      end else if (Req0 || Req1) begin
        mOwner = (Req0 && Req1) ? ((mLast == 1) ? 0 : 1) : (Req0 ? 0 : 1);
        mWords = 0; mIdle = 0;
      end
    end
  end

  always @(negedge Clock) begin
    chk("gnt0", Gnt0, mOwner == 0);
    chk("gnt1", Gnt1, mOwner == 1);
    chk("sersend", SerSend, mSend);
    chk("serdatain", SerDataIn, mData);
    chk("drop", Drop, mDrop);
    chk("serread", SerRead, SerValid && ((Rd0 && mOwner == 0) || (Rd1 && mOwner == 1)));
    chk("rdvalid0", RdValid0, SerValid && mOwner == 0);
    chk("rdvalid1", RdValid1, SerValid && mOwner == 1);
    chk("rddata", RdData, SerDataOut);
  end

  logic [15:0] sendQ[$];
  always @(negedge Clock) if (SerSend === 1'b1) sendQ.push_back(SerDataIn);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    step(2);
    Reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    Reset_n = 1'b0;
    {Req0, Req1, Lock0, Lock1, Wr0, Wr1, Rd0, Rd1} = '0;
    WrData0 = '0; WrData1 = '0; SerDataOut = '0;
    SerValid = 1'b1; Rd0 = 1'b1;
    step(3);
    chk("rst_gnt0", Gnt0, 0);
    chk("rst_gnt1", Gnt1, 0);
    chk("rst_sersend", SerSend, 0);
    chk("rst_drop", Drop, 0);
    chk("rst_serdatain", SerDataIn, 0);
    chk("rst_serread", SerRead, 0);
    SerValid = 1'b0; Rd0 = 1'b0;
    Reset_n = 1'b1;
    step(1);

    // three-word burst from port 0
    sendQ.delete();
    Req0 = 1'b1;
    step(1);
    chk("t1_gnt_latency", Gnt0, 1);
    Wr0 = 1'b1; WrData0 = 16'h1111; step(1);
    WrData0 = 16'h2222; step(1);
    WrData0 = 16'h3333; step(1);
    Wr0 = 1'b0; step(2);
    chk("t1_send_count", sendQ.size(), 3);
    if (sendQ.size() == 3) begin
      chk("t1_word0", sendQ[0], 16'h1111);
      chk("t1_word1", sendQ[1], 16'h2222);
      chk("t1_word2", sendQ[2], 16'h3333);
    end
    Req0 = 1'b0; step(3);

    // tie from reset goes to port 0, then hand-over to port 1
    doReset();
    Req0 = 1'b1; Req1 = 1'b1;
    step(1);
    chk("t2_tie_gnt0", Gnt0, 1);
    chk("t2_tie_gnt1", Gnt1, 0);
    step(2);
    Req0 = 1'b0;
    step(1);
    chk("t2_turn_gnt0", Gnt0, 0);
    chk("t2_turn_gnt1", Gnt1, 0);
    step(2);
    chk("t2_gnt1", Gnt1, 1);
    Req1 = 1'b0; step(3);

    // burst-limit release after eighth word
    Req0 = 1'b1; step(1);
    Req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Wr0 = 1'b1; WrData0 = 16'h0100 + 16'(i); step(1);
    end
    Wr0 = 1'b0;
    chk("t3_still_gnt0", Gnt0, 1);
    step(1);
    chk("t3_turn", Gnt0, 0);
    step(2);
    chk("t3_gnt1", Gnt1, 1);

    // idle-limit release of port 1 while port 0 waits
    n = 0;
    while (Gnt1 === 1'b1 && n < 400) begin
      n++;
      step(1);
    end
    chk("t4_idle_hold_cycles", n, 256);
    step(2);
    chk("t4_gnt0", Gnt0, 1);

    // locked burst is not cut, but dropping Req still releases
    Lock0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Wr0 = 1'b1; WrData0 = 16'h0200 + 16'(i); step(1);
    end
    Wr0 = 1'b0;
    step(5);
    chk("t5_locked_gnt0", Gnt0, 1);
    Req0 = 1'b0;
    step(1);
    chk("t5_lock_release", Gnt0, 0);
    Lock0 = 1'b0;
    step(2);
    chk("t5_gnt1", Gnt1, 1);
    step(300);
    chk("t5_gnt1_kept", Gnt1, 1);

    // non-owner write drop and read routing
    Wr0 = 1'b1; WrData0 = 16'hBEEF; step(1);
    chk("t6_drop", Drop, 1);
    chk("t6_no_send", SerSend, 0);
    Wr0 = 1'b0; step(1);
    chk("t6_drop_clear", Drop, 0);
    SerValid = 1'b1; Rd1 = 1'b1; SerDataOut = 16'h5A5A; #1;
    chk("t6_serread", SerRead, 1);
    chk("t6_rdvalid0", RdValid0, 0);
    chk("t6_rdvalid1", RdValid1, 1);
    chk("t6_rddata", RdData, 16'h5A5A);
    Rd1 = 1'b0; Rd0 = 1'b1; #1;
    chk("t6_nonowner_rd", SerRead, 0);
    Rd0 = 1'b0;
    Wr0 = 1'b1; WrData0 = 16'hAAAA; Wr1 = 1'b1; WrData1 = 16'h5555; step(1);
    chk("t6_both_send", SerSend, 1);
    chk("t6_both_data", SerDataIn, 16'h5555);
    chk("t6_both_drop", Drop, 1);
    Wr0 = 1'b0;
    Req1 = 1'b0; WrData1 = 16'h7777; step(1);
    chk("t6_leave_gnt1", Gnt1, 0);
    chk("t6_leave_send", SerSend, 1);
    chk("t6_leave_data", SerDataIn, 16'h7777);
    WrData1 = 16'h8888; step(1);
    chk("t6_turn_drop", Drop, 1);
    chk("t6_turn_nosend", SerSend, 0);
    Wr1 = 1'b0; SerValid = 1'b0; SerDataOut = '0;
    step(2);

    // asynchronous reset during a burst
    Req0 = 1'b1; step(1);
    Wr0 = 1'b1; WrData0 = 16'hCAFE; step(1);
    #2 Reset_n = 1'b0;
    #1;
    chk("t7_rst_gnt0", Gnt0, 0);
    chk("t7_rst_sersend", SerSend, 0);
    chk("t7_rst_serdatain", SerDataIn, 0);
    chk("t7_rst_drop", Drop, 0);
    Wr0 = 1'b0; Req0 = 1'b0;
    step(2);
    Reset_n = 1'b1;
    sendQ.delete();
    step(4);
    chk("t7_no_send_after", sendQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8: max words the owner may write before forced release when the other port requests.
REQ-002 Parameter IDLE_MAX, default 255: owner-inactivity cycles before forced release when the other port requests.
REQ-003 Clock  in  1  single clock; all logic on rising edge.
REQ-004 Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Req0/Req1  in  1  requester wants the serial port.
REQ-006 Lock0/Lock1  in  1  owner suppresses the BURST_MAX release.
REQ-007 Wr0/Wr1  in  1  one-word transmit strobe.
REQ-008 WrData0/WrData1  in  16  transmit word.
REQ-009 Rd0/Rd1  in  1  consume the current received word.
REQ-010 Gnt0/Gnt1  out  1  ownership, registered, one-hot or zero.
REQ-011 RdData  out  16  received word, equals SerDataOut.
REQ-012 RdValid0/RdValid1  out  1  received word available to that port.
REQ-013 Drop  out  1  one-cycle pulse: Wr from non-owner discarded.
REQ-014 SerSend  out  1  registered push strobe to serial controller.
REQ-015 SerDataIn  out  16  registered word to serial controller.
REQ-016 SerRead  out  1  combinational pop strobe to serial controller.
REQ-017 SerDataOut  in  16  controller receive-buffer head word.
REQ-018 SerValid  in  1  controller receive buffer non-empty.

Function
REQ-019 FSM states IDLE, OWN0, OWN1, TURN; Gnt0 high only in OWN0, Gnt1 only in OWN1.
REQ-020 IDLE: single requester -> its OWN state next cycle; both -> port not equal to LastOwner (LastOwner resets to 1, so port 0 wins first tie).
REQ-021 OWNn -> TURN when Reqn low, or other Req high and (WordCnt==BURST_MAX with Lockn low, or IdleCnt==IDLE_MAX).
REQ-022 TURN lasts exactly one cycle, both grants low, LastOwner updated, then -> IDLE.
REQ-023 Gnt latency: Req sampled high in IDLE -> Gnt high the following cycle.
REQ-024 Owner Wr -> SerSend=1 and SerDataIn=owner WrData one cycle later; one SerSend per Wr, no coalescing.
REQ-025 Wr while not owner (incl. IDLE/TURN) -> discarded, Drop=1 next cycle; both ports writing -> owner's accepted, other dropped.
REQ-026 WordCnt (8-bit, saturating) clears on grant entry, increments per accepted Wr.
REQ-027 IdleCnt (8-bit, saturating) clears on grant entry and on any owner Wr or Rd, else increments.
REQ-028 RdValidn = SerValid & Gntn; SerRead = SerValid & Rdn & Gntn, same cycle; non-owner Rd ignored.
REQ-029 Owner Wr on the cycle the FSM leaves OWNn is accepted; Wr in TURN is dropped.
REQ-030 Lock has no effect on Reqn-low release or IDLE_MAX release.

Reset
REQ-031 Reset_n low: state IDLE, LastOwner=1, WordCnt=IdleCnt=0, Gnt0=Gnt1=SerSend=Drop=0, SerDataIn=0, immediately.
REQ-032 Reset mid-burst discards any pending SerSend; first grant after release follows REQ-020/REQ-023.

Structure
REQ-033 FSM state encodings and the BURST_MAX/IDLE_MAX defaults SHALL live in the shared serial package.
REQ-034 Single module, no sub-modules; instantiated alongside SerialController, driving its Send/DataIn/Read.

Verification
REQ-035 Req0 only, Wr0 x3 (0x1111,0x2222,0x3333) -> Gnt0 after 1 cycle, three SerSend pulses with those words in order.
REQ-036 Req0,Req1 same cycle from reset -> Gnt0; Req0 drop -> TURN one cycle -> Gnt1.
REQ-037 Req0 holding, Lock0=0, Req1 high, 8 writes -> release after 8th, Gnt1 two cycles later; with Lock0=1 -> no release.
REQ-038 Owner 1 idle 255 cycles with Req0 high -> release, Gnt0; Req0 low -> Gnt1 kept indefinitely.
REQ-039 Gnt1 held, Wr0=1 data 0xBEEF -> Drop pulse, no SerSend; SerValid=1, Rd1 -> SerRead same cycle, RdValid0 stays 0.
REQ-040 Reset_n low during OWN0 with pending write -> all outputs zero asynchronously, no SerSend after release.
